jpeg_frame_sequencer: RTL

//  Feeds a complete frame from memory into the JPEG encoder wrapper as 8x8 RGB blocks.

---
 rtl/jpeg_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_frame_sequencer.sv
// Streams a frame from memory into the JPEG encoder slave port as raster-ordered 8x8 RGB blocks.
// Defining JPEG_SEQ_PERF_CNT_EN adds the stall_cnt output and its saturating counter.
module jpeg_frame_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [DIM_W-1:0]  cfg_blk_w,
   input  logic [DIM_W-1:0]  cfg_blk_h,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              error,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              enc_req,
   output logic              enc_wen,
   output logic [9:0]        enc_add,
   output logic [31:0]       enc_wdata,
   input  logic              enc_gnt,
   input  logic              enc_fifo_irq,
   input  logic              enc_end_irq,
`ifdef JPEG_SEQ_PERF_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   input  logic              enc_err_irq
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BLK_CHK,
      S_FETCH,
      S_WAIT_DATA,
      S_WRITE,
      S_DRAIN,
      S_ERROR
   } state_t;

   state_t              state_q;
   logic                done_q;
   logic                cfg_err_q;
   logic                error_q;
   logic                mem_req_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                enc_req_q;
   logic                enc_last_q;
   logic [31:0]         enc_wdata_q;

   logic [ADDR_W-1:0]   stride_q;
   logic [DIM_W-1:0]    blk_w_q;
   logic [DIM_W-1:0]    blk_h_q;
   logic [DIM_W-1:0]    bx_q;
   logic [DIM_W-1:0]    by_q;
   logic [5:0]          pix_q;
   logic [ADDR_W-1:0]   line_addr_q;
   logic [ADDR_W-1:0]   blk_base_q;
   logic [ADDR_W-1:0]   row_base_q;

   logic [ADDR_W-1:0]   pix_addr_d;
   logic [ADDR_W-1:0]   line_addr_d;
   logic [ADDR_W-1:0]   blk_base_d;
   logic [ADDR_W-1:0]   row_base_d;
   logic [DIM_W-1:0]    bx_d;
   logic [DIM_W-1:0]    by_d;
   logic                last_blk;
   logic                bx_last;
   logic                by_last;

   assign bx_last  = (bx_q == blk_w_q - DIM_W'(1));
   assign by_last  = (by_q == blk_h_q - DIM_W'(1));
   assign last_blk = bx_last && by_last;

   // Addresses advance incrementally: pixel -> line -> block column -> block row,
   // so no multiplier is needed; everything wraps modulo 2^ADDR_W.
   always_comb begin
      pix_addr_d  = mem_addr_q + ADDR_W'(4);
      line_addr_d = line_addr_q;
      blk_base_d  = blk_base_q;
      row_base_d  = row_base_q;
      bx_d        = bx_q;
      by_d        = by_q;
      if (pix_q[2:0] == 3'd7) begin
         if (pix_q[5:3] != 3'd7) begin
            line_addr_d = line_addr_q + stride_q;
            pix_addr_d  = line_addr_d;
         end else if (!bx_last) begin
            bx_d        = bx_q + DIM_W'(1);
            blk_base_d  = blk_base_q + ADDR_W'(32);
            line_addr_d = blk_base_d;
            pix_addr_d  = blk_base_d;
         end else begin
            bx_d        = '0;
            by_d        = by_q + DIM_W'(1);
            row_base_d  = row_base_q + (stride_q << 3);
            blk_base_d  = row_base_d;
            line_addr_d = row_base_d;
            pix_addr_d  = row_base_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         error_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         enc_req_q   <= 1'b0;
         enc_last_q  <= 1'b0;
         enc_wdata_q <= '0;
         stride_q    <= '0;
         blk_w_q     <= '0;
         blk_h_q     <= '0;
         bx_q        <= '0;
         by_q        <= '0;
         pix_q       <= '0;
         line_addr_q <= '0;
         blk_base_q  <= '0;
         row_base_q  <= '0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         // Abort outranks everything, including an encoder error in the same cycle.
         if (abort) begin
            state_q   <= S_IDLE;
            error_q   <= 1'b0;
            mem_req_q <= 1'b0;
            enc_req_q <= 1'b0;
         end else if (enc_err_irq && (state_q != S_IDLE)) begin
            state_q   <= S_ERROR;
            error_q   <= 1'b1;
            mem_req_q <= 1'b0;
            enc_req_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     if ((cfg_blk_w == '0) || (cfg_blk_h == '0)) begin
                        cfg_err_q <= 1'b1;
                     end else begin
                        stride_q    <= cfg_stride;
                        blk_w_q     <= cfg_blk_w;
                        blk_h_q     <= cfg_blk_h;
                        bx_q        <= '0;
                        by_q        <= '0;
                        pix_q       <= '0;
                        mem_addr_q  <= cfg_base;
                        line_addr_q <= cfg_base;
                        blk_base_q  <= cfg_base;
                        row_base_q  <= cfg_base;
                        state_q     <= S_BLK_CHK;
                     end
                  end
               end
               S_BLK_CHK: begin
                  if (!enc_fifo_irq) begin
                     mem_req_q <= 1'b1;
                     state_q   <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  if (mem_gnt) begin
                     mem_req_q <= 1'b0;
                     state_q   <= S_WAIT_DATA;
                  end
               end
               S_WAIT_DATA: begin
                  if (mem_rvalid) begin
                     enc_wdata_q <= mem_rdata;
                     enc_last_q  <= last_blk;
                     enc_req_q   <= 1'b1;
                     state_q     <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  if (enc_gnt) begin
                     enc_req_q   <= 1'b0;
                     pix_q       <= pix_q + 6'd1;
                     mem_addr_q  <= pix_addr_d;
                     line_addr_q <= line_addr_d;
                     blk_base_q  <= blk_base_d;
                     row_base_q  <= row_base_d;
                     bx_q        <= bx_d;
                     by_q        <= by_d;
                     if (pix_q != 6'd63) begin
                        mem_req_q <= 1'b1;
                        state_q   <= S_FETCH;
                     end else if (!last_blk) begin
                        state_q <= S_BLK_CHK;
                     end else begin
                        state_q <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  if (enc_end_irq) begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
               S_ERROR: begin
                  state_q <= S_ERROR;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef JPEG_SEQ_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic        start_ok;
   logic        stalled;

   assign start_ok = start && !abort && (state_q == S_IDLE) &&
                     (cfg_blk_w != '0) && (cfg_blk_h != '0);
   assign stalled  = ((state_q == S_BLK_CHK) && enc_fifo_irq) ||
                     ((state_q == S_WRITE) && !enc_gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (start_ok) begin
         stall_cnt_q <= '0;
      end else if (stalled && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
   assign error     = error_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign enc_req   = enc_req_q;
   assign enc_wen   = 1'b0;
   assign enc_add   = {1'b0, enc_last_q, 8'h00};
   assign enc_wdata = enc_wdata_q;

endmodule
